// File: rtl/serial_add_ctrl.sv
//==============================================================================
// Module   : serial_add_ctrl
// Brief    : Sequencer and operand store for a bit-serial adder.
//            Computes {cout, sum} = a + b + cin, LSB first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  input  logic                       cin,
  input  logic                       pause,
  output logic                       busy,
  output logic                       shift_ctrl,
  output logic                       done,
  output logic [WIDTH-1:0]           sum,
  output logic                       cout,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic               w_load;
  logic               w_shift;
  logic               w_s;
  logic               w_c;

  // One full adder on the current LSBs of the operand registers.
  assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!pause) begin
          w_shift = 1'b1;
          if (r_bit_cnt == C_LAST_BIT) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_a       <= a_in;
        r_b       <= b_in;
        r_carry   <= cin;
        r_sum     <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_sum     <= {w_s, r_sum[WIDTH-1:1]};
        r_a       <= r_a >> 1;
        r_b       <= r_b >> 1;
        r_carry   <= w_c;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign shift_ctrl = (r_state == S_SHIFT) && !pause;
  assign done       = (r_state == S_DONE);
  assign sum        = r_sum;
  assign cout       = r_carry;
  assign bit_cnt    = r_bit_cnt;

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer and operand store for the bit-serial adder: one carry flip-flop, one full adder, and a right-shifting sum register. It accepts a start request with two WIDTH-bit operands and a carry-in. It then drives the shift-enable for exactly WIDTH active cycles, LSB first, and reports the sum and carry-out with a one-cycle done pulse. It sits between a requester that issues add commands and the serial datapath, and replaces manual shift-control toggling.

## Interface
- WIDTH, 4, operand/sum width in bits; legal range 2..32

- clk  input  1  single clock, all state updates on rising edge
- clear  input  1  reset, synchronous, active-high; wins over every other input
- start  input  1  request; accepted only in IDLE
- a_in  input  WIDTH  operand A, sampled on the accepting edge
- b_in  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in, sampled on the accepting edge
- pause  input  1  freezes shifting while in SHIFT
- busy  output  1  high in SHIFT and DONE
- shift_ctrl  output  1  high in SHIFT when pause=0; this is the datapath shift enable
- done  output  1  one-cycle pulse in DONE
- sum  output  WIDTH  result register
- cout  output  1  carry flip-flop value
- bit_cnt  output  clog2(WIDTH+1)  number of bits processed so far

## Operation
- States are IDLE, SHIFT and DONE. All are registered; outputs decode from state and registers with no combinational path from start.
- IDLE, start=1, clear=0:
  - a_reg←a_in, b_reg←b_in, carry←cin, sum←0, bit_cnt←0
  - next state is SHIFT
- IDLE, start=0: all registers hold, so sum and cout keep the last result.
- SHIFT, pause=0, on each edge:
  - s = a_reg[0]^b_reg[0]^carry; c = majority(a_reg[0], b_reg[0], carry)
  - sum←{s, sum[WIDTH-1:1]}; a_reg←a_reg>>1; b_reg←b_reg>>1; carry←c; bit_cnt←bit_cnt+1
  - if bit_cnt==WIDTH-1 before the edge, next state is DONE
- SHIFT, pause=1: every register holds and shift_ctrl=0.
- DONE:
  - done=1; sum and cout are final; bit_cnt=WIDTH
  - next state is IDLE unconditionally; start is ignored in DONE
- start while busy=1 is ignored and not queued.
- Arithmetic: {cout, sum} = a_in + b_in + cin, modulo 2^(WIDTH+1); nothing overflows beyond cout.
- clear=1 (any state, any cycle):
  - state←IDLE; sum, cout, a_reg, b_reg, bit_cnt ← 0
  - a clear mid-operation aborts it; done is not produced for an aborted operation.

## Timing
- Reset values: busy=0, shift_ctrl=0, done=0, sum=0, cout=0, bit_cnt=0.
- Accepting edge E0 moves the block to SHIFT; shift_ctrl is high from the cycle after E0.
- Without pause, shift edges are E1..E(WIDTH). done is high in the cycle after E(WIDTH), i.e. WIDTH+1 cycles after the start cycle.
- Each pause cycle inside SHIFT adds exactly one cycle of latency.
- pause is ignored in IDLE and DONE.
- Back-to-back: if start is held high, the next operation is accepted in the first IDLE cycle after DONE. Throughput is one add per WIDTH+2 cycles.
- clear and start in the same cycle: clear wins and the request is dropped.

## Test plan
- Reset: clear=1 for 2 cycles in any state -> busy=0, done=0, shift_ctrl=0, sum=0, cout=0, bit_cnt=0.
- WIDTH=4, a=5, b=3, cin=0, one-cycle start -> shift_ctrl high for exactly 4 cycles; done pulses 5 cycles after start; sum=8, cout=0; both hold until the next start.
- Carry cases:
  - a=15, b=1, cin=0 -> sum=0, cout=1
  - a=15, b=15, cin=1 -> sum=15, cout=1
  - a=0, b=0, cin=1 -> sum=1, cout=0
- a=9, b=7, cin=0, pause=1 during the 2nd and 3rd shift cycles -> done delayed by 2 cycles; sum=0, cout=1; bit_cnt holds at 1 during the pause.
- Abort and ignore:
  - start pulsed while in SHIFT -> ignored; the result matches the first operands
  - clear=1 at the 2nd shift cycle -> IDLE next cycle, no done, sum=0, cout=0
- start held high for 20 cycles, a=2, b=2 -> done every 6 cycles; each result is sum=4; no lost or extra done pulses.
